// File: rtl/lmu_lqsignacc_pkg.sv
// rtl/lmu_lqsignacc_pkg.sv - shared LQ sizing, FSM encoding and result-entry width
package lmu_lqsignacc_pkg;

  localparam int NUM_LQ    = 8;
  localparam int LQADDR_BW = 3;
  // Result entry layout: {idx, signZ, signX}
  localparam int RES_W     = LQADDR_BW + 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } lqsa_state_e;

endpackage

// File: rtl/lmu_lqsignacc_fifo.sv
// rtl/lmu_lqsignacc_fifo.sv - generic synchronous FIFO with full/empty/count
module lmu_lqsignacc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A write into a full FIFO is accepted when the head leaves on the same edge
  assign do_wr   = wr_en && (!full || rd_en);
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lmu_lqsignacc.sv
// rtl/lmu_lqsignacc.sv - LQ sign accumulator with ordered result drain; err_drop under LMU_LQSIGNACC_ERR_EN
module lmu_lqsignacc
  import lmu_lqsignacc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 temp_en,
  input  logic                 lqsign_valid,
  input  logic [LQADDR_BW-1:0] lqsign_valid_idx,
  input  logic [NUM_LQ-1:0]    lqsignZ_temp_list,
  input  logic [NUM_LQ-1:0]    lqsignX_temp_list,
  input  logic                 interpret_done,
  output logic [NUM_LQ-1:0]    lqsignZ_acc_reg,
  output logic [NUM_LQ-1:0]    lqsignX_acc_reg,
  output logic                 busy,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [LQADDR_BW-1:0] res_idx,
  output logic                 res_signZ,
  output logic                 res_signX
`ifdef LMU_LQSIGNACC_ERR_EN
  ,
  output logic                 err_drop
`endif
);

  lqsa_state_e              state_q, state_d;
  logic [NUM_LQ-1:0]        pending_q;
  logic [NUM_LQ-1:0]        meas_mask;
  logic [NUM_LQ-1:0]        pend_set;
  logic [NUM_LQ-1:0]        sel_onehot;
  logic [LQADDR_BW-1:0]     sel_idx;
  logic                     accept_temp;
  logic                     meas;
  logic                     push;
  logic                     pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [RES_W-1:0]         wr_data;
  logic [RES_W-1:0]         rd_data;

  assign accept_temp = temp_en && (state_q != ST_DRAIN);
  assign meas        = accept_temp && lqsign_valid;
  assign meas_mask   = meas ? (NUM_LQ'(1) << lqsign_valid_idx) : '0;
  assign pend_set    = pending_q | meas_mask;

  // Lowest pending index wins: scanning downward leaves the smallest set bit
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_LQ - 1; i >= 0; i--) begin
      if (pending_q[i]) sel_idx = LQADDR_BW'(i);
    end
    sel_onehot = NUM_LQ'(1) << sel_idx;
  end

  assign pop     = res_ready && !fifo_empty;
  assign push    = (state_q == ST_DRAIN) && (|pending_q) && (!fifo_full || pop);
  assign wr_data = {sel_idx, lqsignZ_acc_reg[sel_idx], lqsignX_acc_reg[sel_idx]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (interpret_done && (temp_en || (|pend_set))) state_d = ST_DRAIN;
        else if (temp_en)                               state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (interpret_done) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Leave on the edge of the final push so busy drops right after it
        if (!(|pending_q) || (push && !(|(pending_q & ~sel_onehot)))) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      pending_q       <= '0;
      lqsignZ_acc_reg <= '0;
      lqsignX_acc_reg <= '0;
    end else begin
      state_q <= state_d;
      if (accept_temp) begin
        pending_q       <= pend_set;
        lqsignZ_acc_reg <= lqsignZ_acc_reg ^ lqsignZ_temp_list;
        lqsignX_acc_reg <= lqsignX_acc_reg ^ lqsignX_temp_list;
      end else if (push) begin
        pending_q       <= pending_q & ~sel_onehot;
        lqsignZ_acc_reg <= lqsignZ_acc_reg & ~sel_onehot;
        lqsignX_acc_reg <= lqsignX_acc_reg & ~sel_onehot;
      end
    end
  end

`ifdef LMU_LQSIGNACC_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_drop <= 1'b0;
    end else if ((temp_en && state_q == ST_DRAIN) || (meas && pending_q[lqsign_valid_idx])) begin
      err_drop <= 1'b1;
    end
  end
`endif

  lmu_lqsignacc_fifo #(
    .WIDTH (RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign busy      = (state_q != ST_IDLE);
  assign res_valid = (fifo_count != '0);
  assign {res_idx, res_signZ, res_signX} = rd_data;

endmodule

// File: tb/tb_lmu_lqsignacc.sv
// tb/tb_lmu_lqsignacc.sv - scoreboard bench with reference model for lmu_lqsignacc
module tb_lmu_lqsignacc;
  import lmu_lqsignacc_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 temp_en, lqsign_valid, interpret_done, res_ready;
  logic [LQADDR_BW-1:0] lqsign_valid_idx;
  logic [NUM_LQ-1:0]    lqsignZ_temp_list, lqsignX_temp_list;
  logic [NUM_LQ-1:0]    lqsignZ_acc_reg, lqsignX_acc_reg;
  logic                 busy, res_valid, res_signZ, res_signX;
  logic [LQADDR_BW-1:0] res_idx;
`ifdef LMU_LQSIGNACC_ERR_EN
  logic                 err_drop;
`endif

  lmu_lqsignacc #(.FIFO_DEPTH(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .temp_en           (temp_en),
    .lqsign_valid      (lqsign_valid),
    .lqsign_valid_idx  (lqsign_valid_idx),
    .lqsignZ_temp_list (lqsignZ_temp_list),
    .lqsignX_temp_list (lqsignX_temp_list),
    .interpret_done    (interpret_done),
    .lqsignZ_acc_reg   (lqsignZ_acc_reg),
    .lqsignX_acc_reg   (lqsignX_acc_reg),
    .busy              (busy),
    .res_valid         (res_valid),
    .res_ready         (res_ready),
    .res_idx           (res_idx),
    .res_signZ         (res_signZ),
    .res_signX         (res_signX)
`ifdef LMU_LQSIGNACC_ERR_EN
    ,
    .err_drop          (err_drop)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic rdy_rand = 1'b0;

  // Reference model: sign accumulators, measured set, expected result stream
  logic [NUM_LQ-1:0] m_accz, m_accx, m_pend;
  logic              m_drain, m_err;
  logic [RES_W-1:0]  exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_accz = '0; m_accx = '0; m_pend = '0; m_drain = 1'b0; m_err = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic te, lv, input logic [LQADDR_BW-1:0] idx,
                            input logic [NUM_LQ-1:0] z, x, input logic done);
    if (m_drain) begin
      if (te) m_err = 1'b1;
    end else begin
      if (te) begin
        m_accz ^= z;
        m_accx ^= x;
        if (lv) begin
          if (m_pend[idx]) m_err = 1'b1;
          m_pend[idx] = 1'b1;
        end
      end
      if (done && (te || m_pend != '0)) begin
        for (int i = 0; i < NUM_LQ; i++) begin
          if (m_pend[i]) begin
            exp_q.push_back({LQADDR_BW'(i), m_accz[i], m_accx[i]});
            m_accz[i] = 1'b0;
            m_accx[i] = 1'b0;
          end
        end
        m_pend  = '0;
        m_drain = 1'b1;
      end
    end
  endtask

  task automatic drive(input logic te, lv, input logic [LQADDR_BW-1:0] idx,
                       input logic [NUM_LQ-1:0] z, x, input logic done);
    temp_en = te; lqsign_valid = lv; lqsign_valid_idx = idx;
    lqsignZ_temp_list = z; lqsignX_temp_list = x; interpret_done = done;
    model_step(te, lv, idx, z, x, done);
    @(posedge clk); #1;
    temp_en = 1'b0; lqsign_valid = 1'b0; interpret_done = 1'b0;
    lqsignZ_temp_list = '0; lqsignX_temp_list = '0;
  endtask

  task automatic mark(input logic [LQADDR_BW-1:0] idx);
    drive(1'b1, 1'b1, idx, NUM_LQ'($urandom), NUM_LQ'($urandom), 1'b0);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (!busy && !res_valid) break;
      step(1);
    end
    chk("idle_timeout", {30'd0, busy, res_valid}, 32'd0);
    m_drain = 1'b0;
    chk("sb_drained", exp_q.size(), 0);
    chk("accz_idle", lqsignZ_acc_reg, m_accz);
    chk("accx_idle", lqsignX_acc_reg, m_accx);
`ifdef LMU_LQSIGNACC_ERR_EN
    chk("err_drop", err_drop, m_err);
`endif
  endtask

  // Monitor: every accepted result is popped against the model's stream
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL res_unexpected: actual=%0h required=none", {res_idx, res_signZ, res_signX});
      end else begin
        chk("res_entry", {res_idx, res_signZ, res_signX}, exp_q.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_rand) res_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [LQADDR_BW-1:0] ids[6];
    rst = 1'b1; temp_en = 1'b0; lqsign_valid = 1'b0; lqsign_valid_idx = '0;
    lqsignZ_temp_list = '0; lqsignX_temp_list = '0; interpret_done = 1'b0; res_ready = 1'b1;
    model_reset();
    step(2);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_accz", lqsignZ_acc_reg, 0);
    chk("rst_accx", lqsignX_acc_reg, 0);
    rst = 1'b0;
    step(1);

    // Single LQ
    drive(1, 0, 0, 8'h01, 8'h01, 0);
    chk("single_busy", busy, 1);
    drive(1, 0, 0, 8'h01, 8'h00, 0);
    drive(1, 1, 0, 8'h01, 8'h00, 0);
    drive(0, 0, 0, 8'h00, 8'h00, 1);
    wait_idle(50);
    chk("single_acc0", {lqsignZ_acc_reg[0], lqsignX_acc_reg[0]}, 0);

    // Ordering and latency
    mark(5); mark(2); mark(0);
    drive(0, 0, 0, 0, 0, 1);
    chk("lat_not_yet", res_valid, 0);
    step(1);
    chk("ord_v0", res_valid, 1); chk("ord_i0", res_idx, 0);
    step(1);
    chk("ord_v1", res_valid, 1); chk("ord_i1", res_idx, 2);
    step(1);
    chk("ord_v2", res_valid, 1); chk("ord_i2", res_idx, 5);
    wait_idle(50);

    // Backpressure with six pending LQs
    res_ready = 1'b0;
    ids = '{3'd6, 3'd1, 3'd7, 3'd3, 3'd0, 3'd4};
    foreach (ids[k]) mark(ids[k]);
    drive(0, 0, 0, 0, 0, 1);
    for (int c = 0; c < 10; c++) begin
      step(1);
      chk("bp_valid", res_valid, 1);
      chk("bp_head", {res_idx, res_signZ, res_signX}, exp_q[0]);
      if (c >= 5) chk("bp_stalled_busy", busy, 1);
    end
    res_ready = 1'b1;
    wait_idle(100);

    // Same-cycle temp_en, measure and done
    drive(1, 1, 2, 8'h04, 8'h00, 1);
    wait_idle(50);

    // Randomized rounds with random backpressure
    rdy_rand = 1'b1;
    for (int r = 0; r < 25; r++) begin
      int n = $urandom_range(1, 6);
      for (int c = 0; c < n; c++) begin
        drive(1, 1'($urandom_range(0, 1)), LQADDR_BW'($urandom), NUM_LQ'($urandom),
              NUM_LQ'($urandom), (c == n - 1) && ($urandom_range(0, 1) == 1));
      end
      if (!m_drain) drive(0, 0, 0, 0, 0, 1);
      wait_idle(200);
    end
    rdy_rand = 1'b0;
    res_ready = 1'b1;

    // Asynchronous reset mid-drain with three results buffered
    res_ready = 1'b0;
    mark(1); mark(4); mark(6); mark(7);
    drive(0, 0, 0, 0, 0, 1);
    step(3);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_valid", res_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", res_valid, 0);
    chk("arst_accz", lqsignZ_acc_reg, 0);
    chk("arst_accx", lqsignX_acc_reg, 0);
    chk("arst_busy", busy, 0);
    model_reset();
    step(1);
    rst = 1'b0;
    step(2);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_valid", res_valid, 0);

    // temp_en during a stalled drain is dropped
    for (int k = 0; k < 6; k++) mark(LQADDR_BW'(k));
    drive(0, 0, 0, 0, 0, 1);
    step(8);
    chk("drop_busy", busy, 1);
    drive(1, 1, 7, 8'hFF, 8'hFF, 0);
    step(3);
`ifdef LMU_LQSIGNACC_ERR_EN
    chk("err_sticky", err_drop, 1);
`endif
    res_ready = 1'b1;
    wait_idle(100);

    step(2);
    chk("final_sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
